// File: rtl/key_schedule_engine.sv
// rtl/key_schedule_engine.sv - word-serial AES-128/192/256 key expansion
// One schedule word per cycle through a single shared four-byte S-box group.
module key_schedule_engine #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_index,
  output logic             done
);
  localparam int NR          = NK + 6;
  localparam int TOTAL_WORDS = 4 * (NR + 1);
  localparam int IW          = 6;

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("key_schedule_engine: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [2:0]    wrap_q, wrap_d;
  logic [1:0]    grp_q, grp_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rk_valid_q, rk_valid_d;
  logic [127:0]  rk_data_q, rk_data_d;
  logic [3:0]    rk_index_q, rk_index_d;
  logic [31:0]   win_q [NK];
  logic [31:0]   win_d [NK];
  logic [31:0]   buf_q [3];
  logic [31:0]   buf_d [3];

  logic        hs, out_free, producing;
  logic [31:0] temp_raw, sub_in, sub_out, temp, new_word;

  assign hs        = rk_valid_q && rk_ready;
  assign out_free  = !rk_valid_q || hs;
  assign producing = (state_q == LOAD || state_q == EXPAND) && (grp_q != 2'd3 || out_free);

  always_comb begin
    temp_raw = win_q[NK-1];
    sub_in   = (wrap_q == 3'd0) ? {temp_raw[23:0], temp_raw[31:24]} : temp_raw;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (wrap_q == 3'd0)                 temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && wrap_q == 3'd4) temp = sub_out;
    else                                temp = temp_raw;
    // During LOAD the window rotates, so its head is simply key word i.
    new_word = (state_q == LOAD) ? win_q[0] : (win_q[0] ^ temp);
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    wrap_d     = wrap_q;
    grp_d      = grp_q;
    rnd_d      = rnd_q;
    rcon_d     = rcon_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    win_d      = win_q;
    buf_d      = buf_q;
    if (hs) rk_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < NK; k++) win_d[k] = key_in[32*(NK-k)-1 -: 32];
          i_d     = '0;
          wrap_d  = '0;
          grp_d   = '0;
          rnd_d   = '0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD, EXPAND: begin
        if (producing) begin
          for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
          win_d[NK-1] = new_word;
          i_d    = i_q + 1'b1;
          wrap_d = (wrap_q == 3'(NK - 1)) ? 3'd0 : wrap_q + 3'd1;
          if (state_q == EXPAND && wrap_q == 3'd0)
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          case (grp_q)
            2'd0: buf_d[0] = new_word;
            2'd1: buf_d[1] = new_word;
            2'd2: buf_d[2] = new_word;
            default: begin
              rk_data_d  = {buf_q[0], buf_q[1], buf_q[2], new_word};
              rk_index_d = rnd_q;
              rk_valid_d = 1'b1;
              rnd_d      = rnd_q + 4'd1;
            end
          endcase
          grp_d = grp_q + 2'd1;
          if (state_q == LOAD && i_q == IW'(NK - 1))            state_d = EXPAND;
          if (state_q == EXPAND && i_q == IW'(TOTAL_WORDS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      wrap_q     <= '0;
      grp_q      <= '0;
      rnd_q      <= '0;
      rcon_q     <= 8'h01;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++)  buf_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      wrap_q     <= wrap_d;
      grp_q      <= grp_d;
      rnd_q      <= rnd_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      win_q      <= win_d;
      buf_q      <= buf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_index = rk_index_q;
endmodule

// File: tb/tb_key_schedule_engine.sv
// tb/tb_key_schedule_engine.sv - self-checking bench for key_schedule_engine
// Three instances (NK=4/6/8) checked against a FIPS-197 style reference expansion.
module tb_key_schedule_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         start4, start6, start8, rdy;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic         busy4, busy6, busy8, val4, val6, val8, done4, done6, done8;
  logic [127:0] data4, data6, data8;
  logic [3:0]   idx4, idx6, idx8;

  key_schedule_engine #(.NK(4)) u4 (.clk(clk), .rst(rst), .start(start4), .key_in(key4), .busy(busy4),
    .rk_valid(val4), .rk_ready(rdy), .rk_data(data4), .rk_index(idx4), .done(done4));
  key_schedule_engine #(.NK(6)) u6 (.clk(clk), .rst(rst), .start(start6), .key_in(key6), .busy(busy6),
    .rk_valid(val6), .rk_ready(rdy), .rk_data(data6), .rk_index(idx6), .done(done6));
  key_schedule_engine #(.NK(8)) u8 (.clk(clk), .rst(rst), .start(start8), .key_in(key8), .busy(busy8),
    .rk_valid(val8), .rk_ready(rdy), .rk_data(data8), .rk_index(idx8), .done(done8));

  int           sel_nk = 4;
  logic         cur_valid, cur_done, cur_busy;
  logic [127:0] cur_data;
  logic [3:0]   cur_idx;
  always_comb begin
    cur_valid = val4; cur_done = done4; cur_busy = busy4; cur_data = data4; cur_idx = idx4;
    if (sel_nk == 6) begin
      cur_valid = val6; cur_done = done6; cur_busy = busy6; cur_data = data6; cur_idx = idx6;
    end else if (sel_nk == 8) begin
      cur_valid = val8; cur_done = done8; cur_busy = busy8; cur_data = data8; cur_idx = idx8;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_t [256];
  logic [31:0]  ref_w [60];
  logic [127:0] got_data [16];
  logic [3:0]   got_idx [16];
  int           vrel [16];
  int           n_keys, done_cnt, done_rel, hold_viol;
  logic         timed_out;

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] c, b, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic ref_expand(input int nk, input logic [255:0] key);
    logic [7:0]  rc [10];
    logic [31:0] t;
    rc[0] = 8'h01; rc[1] = 8'h02; rc[2] = 8'h04; rc[3] = 8'h08; rc[4] = 8'h10;
    rc[5] = 8'h20; rc[6] = 8'h40; rc[7] = 8'h80; rc[8] = 8'h1b; rc[9] = 8'h36;
    for (int i = 0; i < nk; i++) ref_w[i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
      else if (nk > 6 && i % nk == 4) t = sub_word(t);
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic set_start(input int nk, input logic [255:0] k);
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    if (nk == 4) begin key4 = k[127:0]; start4 = 1'b1; end
    else if (nk == 6) begin key6 = k[191:0]; start6 = 1'b1; end
    else begin key8 = k; start8 = 1'b1; end
  endtask

  task automatic clear_start();
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  // Starts a run and records handshakes; ready is low for edges (lo_from, lo_from+lo_len].
  task automatic run_seq(input int nk, input logic [255:0] key, input int lo_from, input int lo_len,
                         input int restart_rel, input logic [255:0] key2, input int budget);
    int t0, rel;
    logic stall_prev;
    logic [127:0] pd;
    logic [3:0] pi;
    n_keys = 0; done_cnt = 0; done_rel = -1; hold_viol = 0; timed_out = 1'b0;
    stall_prev = 1'b0; pd = '0; pi = '0;
    for (int k = 0; k < 16; k++) vrel[k] = -1;
    sel_nk = nk;
    @(negedge clk); set_start(nk, key);
    @(negedge clk); t0 = cyc; clear_start();
    forever begin
      rel = cyc - t0;
      if (cur_done) begin done_cnt++; done_rel = rel; end
      if (stall_prev && (cur_data !== pd || cur_idx !== pi)) hold_viol++;
      if (done_cnt > 0) break;
      rdy = !((rel + 1) > lo_from && (rel + 1) <= lo_from + lo_len);
      if (cur_valid && vrel[cur_idx] < 0) vrel[cur_idx] = rel;
      if (cur_valid && rdy && n_keys < 16) begin
        got_data[n_keys] = cur_data; got_idx[n_keys] = cur_idx; n_keys++;
      end
      stall_prev = cur_valid && !rdy; pd = cur_data; pi = cur_idx;
      if (rel == restart_rel) set_start(nk, key2); else clear_start();
      if (rel >= budget) begin timed_out = 1'b1; break; end
      @(negedge clk);
    end
    rdy = 1'b1;
    clear_start();
  endtask

  task automatic test_reset();
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    n_checks++; if (val4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", val4); end
    n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done4); end
    n_checks++; if (data4 !== 128'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data4); end
    n_checks++; if (idx4 !== 4'h0) begin n_fail++; $display("FAIL reset_index got=%h exp=0", idx4); end
    n_checks++; if ({busy6, val6, busy8, val8} !== 4'b0) begin
      n_fail++; $display("FAIL reset_others got=%b exp=0000", {busy6, val6, busy8, val8});
    end
  endtask

  task automatic check_schedule(input string name, input int nk);
    int nr;
    nr = nk + 6;
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout got=1 exp=0", name); end
    n_checks++; if (n_keys !== nr + 1) begin n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, n_keys, nr + 1); end
    for (int r = 0; r < n_keys; r++) begin
      n_checks++;
      if (got_data[r] !== ref_rk(r) || got_idx[r] !== 4'(r)) begin
        n_fail++;
        $display("FAIL %s_round%0d got=%h/%0d exp=%h/%0d", name, r, got_data[r], got_idx[r], ref_rk(r), r);
      end
    end
  endtask

  task automatic test_aes128();
    logic [255:0] k;
    k = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    ref_expand(4, k);
    run_seq(4, k, 0, 0, -1, k, 200);
    check_schedule("aes128", 4);
    n_checks++; if (got_data[0] !== k[127:0]) begin n_fail++; $display("FAIL aes128_r0 got=%h exp=%h", got_data[0], k[127:0]); end
    n_checks++; if (got_data[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_fail++; $display("FAIL aes128_r1_vec got=%h exp=a0fafe1788542cb123a339392a6c7605", got_data[1]);
    end
    n_checks++; if (got_data[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++; $display("FAIL aes128_r10_vec got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", got_data[10]);
    end
    n_checks++; if (vrel[0] !== 4) begin n_fail++; $display("FAIL aes128_r0_latency got=%0d exp=4", vrel[0]); end
    n_checks++; if (vrel[10] !== 44) begin n_fail++; $display("FAIL aes128_r10_latency got=%0d exp=44", vrel[10]); end
    n_checks++; if (done_rel !== 45) begin n_fail++; $display("FAIL aes128_done_time got=%0d exp=45", done_rel); end
    n_checks++; if (cur_busy !== 1'b0) begin n_fail++; $display("FAIL aes128_busy_at_done got=%b exp=0", cur_busy); end
  endtask

  task automatic test_aes192();
    logic [255:0] k;
    k = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
    ref_expand(6, k);
    run_seq(6, k, 0, 0, -1, k, 200);
    check_schedule("aes192", 6);
    n_checks++; if (got_data[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
      n_fail++; $display("FAIL aes192_r1_vec got=%h exp=62f8ead2522c6b7bfe0c91f72402f5a5", got_data[1]);
    end
    n_checks++; if (done_rel !== 53) begin n_fail++; $display("FAIL aes192_done_time got=%0d exp=53", done_rel); end
  endtask

  task automatic test_aes256();
    logic [255:0] k;
    k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    ref_expand(8, k);
    run_seq(8, k, 0, 0, -1, k, 200);
    check_schedule("aes256", 8);
    n_checks++; if (got_data[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
      n_fail++; $display("FAIL aes256_r2_vec got=%h exp=9ba354118e6925afa51a8b5f2067fcde", got_data[2]);
    end
    n_checks++; if (got_data[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      n_fail++; $display("FAIL aes256_r14_vec got=%h exp=fe4890d1e6188d0b046df344706c631e", got_data[14]);
    end
    n_checks++; if (done_rel !== 61) begin n_fail++; $display("FAIL aes256_done_time got=%0d exp=61", done_rel); end
  endtask

  // Round0 is held 8 cycles; the 3-word buffer absorbs 3, so the counter freezes for 5.
  task automatic test_backpressure();
    logic [255:0] k;
    k = {128'h0, $urandom, $urandom, $urandom, $urandom};
    ref_expand(4, k);
    run_seq(4, k, 4, 8, -1, k, 200);
    check_schedule("bp", 4);
    n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    n_checks++; if (done_rel !== 50) begin n_fail++; $display("FAIL bp_done_time got=%0d exp=50", done_rel); end
  endtask

  task automatic test_start_while_busy();
    logic [255:0] k, k2;
    k  = {128'h0, $urandom, $urandom, $urandom, $urandom};
    k2 = ~k;
    ref_expand(4, k);
    run_seq(4, k, 0, 0, 20, k2, 200);
    check_schedule("restart", 4);
    n_checks++; if (done_rel !== 45) begin n_fail++; $display("FAIL restart_done_time got=%0d exp=45", done_rel); end
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] k;
    int t0, bad;
    k = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    sel_nk = 4;
    @(negedge clk); set_start(4, k);
    @(negedge clk); t0 = cyc; clear_start();
    while (cyc - t0 < 24) @(negedge clk);
    n_checks++; if (val4 !== 1'b1 || idx4 !== 4'd5) begin
      n_fail++; $display("FAIL rstmid_pre got=%b/%0d exp=1/5", val4, idx4);
    end
    rst = 1'b1;
    #1;
    n_checks++; if ({busy4, val4, done4, data4, idx4} !== '0) begin
      n_fail++; $display("FAIL rstmid_zero got=%b%b%b %h %h exp=0", busy4, val4, done4, data4, idx4);
    end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (done4 || busy4 || val4) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
    ref_expand(4, k);
    run_seq(4, k, 0, 0, -1, k, 200);
    check_schedule("rstmid_rerun", 4);
    n_checks++; if (done_rel !== 45) begin n_fail++; $display("FAIL rstmid_done_time got=%0d exp=45", done_rel); end
  endtask

  task automatic test_random_keys();
    logic [255:0] k;
    int nk;
    for (int t = 0; t < 6; t++) begin
      nk = (t % 3 == 0) ? 4 : (t % 3 == 1) ? 6 : 8;
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (nk == 4) k[255:128] = '0;
      if (nk == 6) k[255:192] = '0;
      ref_expand(nk, k);
      run_seq(nk, k, int'($urandom_range(0, 30)), int'($urandom_range(0, 12)), -1, k, 300);
      check_schedule("random", nk);
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL random_hold got=%0d exp=0", hold_viol); end
    end
  endtask

  initial begin
    rdy = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_run();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
